pipe_mdu_ctrl: RTL and testbench
================================

# pipe_mdu_ctrl

Sequencing controller for the pipeline's iterative multiply/divide unit (MDU) and its HI/LO register pair. It sits beside the instruction-decode stage. It accepts decoded mult/multu/div/divu operations, issues a start pulse and a cycle countdown to the MDU datapath, and asserts a one-cycle HI/LO write strobe on completion. It also produces a combinational stall for the decode stage, the MDU counterpart of the load-use stall, whenever a following instruction needs the busy unit or its not-yet-written HI/LO result.

## Interface
Parameters:
- MUL_CYCLES, 4: RUN cycles for mult/multu; legal range 1..64.
- DIV_CYCLES, 32: RUN cycles for div/divu; legal range 1..64.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- issue  in  1  decode holds an MDU op this cycle.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- mfhilo  in  1  decode holds mfhi/mflo/mthi/mtlo.
- wpcir  in  1  decode load-use stall in effect (1 = stalled).
- cancel  in  1  abort the in-flight op (squash from a redirect).
- mstart  out  1  one-cycle start pulse to the MDU datapath, registered.
- mop  out  2  latched op for the datapath, registered.
- mcount  out  6  remaining RUN cycles minus one, registered.
- mbusy  out  1  high in RUN.
- hilo_we  out  1  HI/LO write strobe, registered, one cycle.
- mstall  out  1  stall request to decode, combinational.

## Operation
- FSM has three states: IDLE, RUN and DONE. State is held in flops that update only on rising clock.
- The accept condition is `acc = issue & ~wpcir & ~cancel & (state==IDLE | state==DONE)`.
- Transitions from IDLE:
  - acc goes to RUN.
  - Otherwise stay in IDLE.
- Transitions from RUN, in priority order:
  - cancel goes to IDLE.
  - mcount==0 goes to DONE.
  - Otherwise stay in RUN and decrement mcount.
- Transitions from DONE:
  - acc goes to RUN.
  - Otherwise go to IDLE.
- On acc:
  - mop <= op.
  - mcount <= (op[1] ? DIV_CYCLES : MUL_CYCLES) - 1.
  - mstart <= 1.
- mstart is 0 in every other cycle.
- hilo_we <= 1 exactly on the RUN→DONE transition. It is therefore high for the single DONE cycle and low otherwise.
- mbusy = (state==RUN).
- mstall = (state==RUN & (issue | mfhilo)) | (state==DONE & mfhilo).
  - An issue arriving during RUN is held (not accepted) until DONE.
  - A HI/LO access during DONE waits one cycle for the write.
- Squash rules:
  - cancel in RUN: no hilo_we; mcount is frozen; mop is retained.
  - cancel in DONE: does not suppress the write already in progress; it only blocks a same-cycle acc.
- Counter width is 6 bits, unsigned, and never decrements below 0.

## Timing
- Reset takes effect at the first rising edge with resetn=0, in any state including mid-RUN. It forces:
  - state = IDLE
  - mstart = 0
  - mop = 00
  - mcount = 0
  - hilo_we = 0
  - therefore mbusy = 0 and mstall = 0
- A write pending at reset is dropped.
- Latency for an op accepted at edge-cycle T, with N the cycle count:
  - RUN occupies T+1 .. T+N; mstart=1 and mcount=N-1 at T+1.
  - mcount=0 at T+N.
  - DONE with hilo_we=1 at T+N+1.
  - IDLE at T+N+2, or RUN again if a new op is accepted in DONE.
- Back-to-back: an op accepted in DONE starts RUN at T+N+2 with no bubble.
- mstall depends combinationally on issue, mfhilo and registered state. It has no path from wpcir or cancel.

## Test plan
- Reset then issue=1, op=00, MUL_CYCLES=4 at cycle 0 → mstart=1 and mcount=3 at cycle 1; mcount reaches 0 at cycle 4; hilo_we=1 only at cycle 5; IDLE at cycle 6.
- Issue div (op=10, DIV_CYCLES=32); at cycle 10 present mfhilo=1 for three cycles → mstall=1 throughout while in RUN; in DONE (cycle 33) mstall=1 and hilo_we=1; mstall=0 at cycle 34.
- Issue mult, then hold issue=1, op=11 from cycle 2 → mstall=1 in cycles 2–4; op accepted in DONE (cycle 5); second RUN starts cycle 6 with mop=11, mcount=31, mstart=1.
- Issue with wpcir=1 → not accepted, state stays IDLE, mstart=0; drop wpcir next cycle → accepted normally.
- Issue div, assert cancel at cycle 7 → IDLE at cycle 8; hilo_we never asserted; mbusy=0.
- Issue div, pull resetn=0 at cycle 15 → at cycle 16 all outputs at reset values; no hilo_we at any later cycle without a new issue.

Source files
------------

// File: rtl/pipe_mdu_ctrl_if.sv
// Decode-side bundle between the pipeline and the MDU sequencing controller.
// The slave side is the controller; the master side is decode plus the MDU datapath.
interface pipe_mdu_ctrl_if;
    logic       issue;
    logic [1:0] op;
    logic       mfhilo;
    logic       wpcir;
    logic       cancel;
    logic       mstart;
    logic [1:0] mop;
    logic [5:0] mcount;
    logic       mbusy;
    logic       hilo_we;
    logic       mstall;

    modport master (
        output issue, op, mfhilo, wpcir, cancel,
        input  mstart, mop, mcount, mbusy, hilo_we, mstall
    );

    modport slave (
        input  issue, op, mfhilo, wpcir, cancel,
        output mstart, mop, mcount, mbusy, hilo_we, mstall
    );
endinterface

// File: rtl/pipe_mdu_ctrl.sv
// Sequencer for the iterative multiply/divide unit: start pulse, RUN countdown,
// HI/LO write strobe on completion, and the decode stall for MDU hazards.
module pipe_mdu_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clock,
    input  logic            resetn,
    pipe_mdu_ctrl_if.slave  mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_r;
    state_t     state_nx_s;
    logic       acc_s;
    logic       mstart_r;
    logic [1:0] mop_r;
    logic [5:0] mcount_r;
    logic       hilo_we_r;
    logic       mstart_nx_s;
    logic [1:0] mop_nx_s;
    logic [5:0] mcount_nx_s;
    logic       hilo_we_nx_s;
    logic       mbusy_s;
    logic       mstall_s;

    // State and datapath-facing output registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            mstart_r  <= 1'b0;
            mop_r     <= 2'b00;
            mcount_r  <= 6'd0;
            hilo_we_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            mstart_r  <= mstart_nx_s;
            mop_r     <= mop_nx_s;
            mcount_r  <= mcount_nx_s;
            hilo_we_r <= hilo_we_nx_s;
        end
    end

    // Next-state logic; an op is accepted only when the unit is free or finishing.
    always_comb begin
        acc_s      = mdu.issue & ~mdu.wpcir & ~mdu.cancel &
                     ((state_r == ST_IDLE) | (state_r == ST_DONE));
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) state_nx_s = ST_RUN;
                else       state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (mdu.cancel)             state_nx_s = ST_IDLE;
                else if (mcount_r == 6'd0)  state_nx_s = ST_DONE;
                else                        state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (acc_s) state_nx_s = ST_RUN;
                else       state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output logic: register next-values plus the combinational busy/stall.
    // A cancelled RUN freezes mcount and keeps mop so the squash leaves no trace.
    always_comb begin
        mstart_nx_s  = 1'b0;
        mop_nx_s     = mop_r;
        mcount_nx_s  = mcount_r;
        hilo_we_nx_s = 1'b0;
        if (acc_s) begin
            mstart_nx_s = 1'b1;
            mop_nx_s    = mdu.op;
            mcount_nx_s = mdu.op[1] ? DIV_LOAD : MUL_LOAD;
        end else if ((state_r == ST_RUN) && !mdu.cancel) begin
            if (mcount_r == 6'd0) hilo_we_nx_s = 1'b1;
            else                  mcount_nx_s  = mcount_r - 6'd1;
        end else begin
            mcount_nx_s = mcount_r;
        end
        mbusy_s  = (state_r == ST_RUN);
        mstall_s = ((state_r == ST_RUN)  & (mdu.issue | mdu.mfhilo)) |
                   ((state_r == ST_DONE) & mdu.mfhilo);
    end

    assign mdu.mstart  = mstart_r;
    assign mdu.mop     = mop_r;
    assign mdu.mcount  = mcount_r;
    assign mdu.hilo_we = hilo_we_r;
    assign mdu.mbusy   = mbusy_s;
    assign mdu.mstall  = mstall_s;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Bench for pipe_mdu_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a timestamp-based reference model.
module tb_pipe_mdu_ctrl;
    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic clock;
    logic resetn;
    int   nvec;
    int   nbad;

    pipe_mdu_ctrl_if mdu_if ();

    pipe_mdu_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .mdu    (mdu_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         rn;
        bit         iss;
        logic [1:0] op;
        bit         mf;
        bit         wp;
        bit         cn;
        bit         e_start;
        logic [1:0] e_mop;
        int         e_cnt;
        bit         e_busy;
        bit         e_we;
        bit         e_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit iss, logic [1:0] op, bit mf, bit wp, bit cn,
                                bit st, logic [1:0] mo, int cnt, bit bz, bit we, bit sl);
        vec_t v;
        v.rn = rn; v.iss = iss; v.op = op; v.mf = mf; v.wp = wp; v.cn = cn;
        v.e_start = st; v.e_mop = mo; v.e_cnt = cnt; v.e_busy = bz; v.e_we = we; v.e_stall = sl;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are sampled 1 unit later.
    task automatic step_in(input bit rn, input bit iss, input logic [1:0] o,
                           input bit mf, input bit wp, input bit cn);
        @(negedge clock);
        resetn        = rn;
        mdu_if.issue  = iss;
        mdu_if.op     = o;
        mdu_if.mfhilo = mf;
        mdu_if.wpcir  = wp;
        mdu_if.cancel = cn;
        #1;
    endtask

    task automatic chk_all(input string nm, input bit st, input logic [1:0] mo, input int cnt,
                           input bit bz, input bit we, input bit sl);
        chk({nm, ".mstart"},  int'(mdu_if.mstart),  int'(st));
        chk({nm, ".mop"},     int'(mdu_if.mop),     int'(mo));
        chk({nm, ".mcount"},  int'(mdu_if.mcount),  cnt);
        chk({nm, ".mbusy"},   int'(mdu_if.mbusy),   int'(bz));
        chk({nm, ".hilo_we"}, int'(mdu_if.hilo_we), int'(we));
        chk({nm, ".mstall"},  int'(mdu_if.mstall),  int'(sl));
    endtask

    // Reference model state: timestamps of the current op rather than an FSM.
    bit         m_run;
    int         m_end;
    int         m_start;
    int         m_done;
    logic [1:0] m_mop;
    int         m_frz;

    initial begin
        nvec = 0;
        nbad = 0;
        resetn = 1'b0;
        mdu_if.issue = 1'b0; mdu_if.op = 2'b00; mdu_if.mfhilo = 1'b0;
        mdu_if.wpcir = 1'b0; mdu_if.cancel = 1'b0;

        // Table: mult latency, wpcir hold-off, div cancel, mid-run reset, cancel in DONE.
        tbl.push_back(mk(1,1,2'b00,0,0,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 1,2'b00, 3,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 2,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 1,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,0,1,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,1,2'b10,0,1,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,1,2'b10,0,0,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 1,2'b10,31,1,0,0));
        tbl.push_back(mk(1,0,2'b00,1,0,0, 0,2'b10,30,1,0,1));
        tbl.push_back(mk(1,1,2'b01,0,0,0, 0,2'b10,29,1,0,1));
        tbl.push_back(mk(1,0,2'b00,0,0,1, 0,2'b10,28,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b10,28,0,0,0));
        tbl.push_back(mk(1,1,2'b01,0,0,0, 0,2'b10,28,0,0,0));
        tbl.push_back(mk(1,0,2'b00,1,0,0, 1,2'b01, 3,1,0,1));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 0,2'b01, 2,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,1,2'b00,0,0,0, 0,2'b00, 0,0,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 1,2'b00, 3,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 2,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 1,1,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,1,0,0));
        tbl.push_back(mk(1,1,2'b10,1,0,1, 0,2'b00, 0,0,1,1));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,2'b00, 0,0,0,0));

        step_in(0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            step_in(tbl[i].rn, tbl[i].iss, tbl[i].op, tbl[i].mf, tbl[i].wp, tbl[i].cn);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].e_start, tbl[i].e_mop, tbl[i].e_cnt,
                    tbl[i].e_busy, tbl[i].e_we, tbl[i].e_stall);
        end

        // Div with HI/LO accesses during RUN and during DONE.
        step_in(0, 0, 2'b00, 0, 0, 0);
        step_in(1, 1, 2'b10, 0, 0, 0);
        for (int c = 1; c <= 34; c++) begin
            bit mf;
            mf = ((c >= 10) && (c <= 12)) || (c >= 33);
            step_in(1, 0, 2'b00, mf, 0, 0);
            if ((c >= 10) && (c <= 12)) chk($sformatf("div.stall_run@%0d", c), int'(mdu_if.mstall), 1);
            if (c == 32) chk("div.mcount0@32", int'(mdu_if.mcount), 0);
            if (c == 33) begin
                chk("div.stall_done@33", int'(mdu_if.mstall), 1);
                chk("div.hilo_we@33", int'(mdu_if.hilo_we), 1);
            end
            if (c == 34) begin
                chk("div.stall@34", int'(mdu_if.mstall), 0);
                chk("div.busy@34", int'(mdu_if.mbusy), 0);
            end
        end

        // Back-to-back: divu held during a mult and accepted in its DONE cycle.
        step_in(0, 0, 2'b00, 0, 0, 0);
        step_in(1, 1, 2'b00, 0, 0, 0);
        step_in(1, 0, 2'b00, 0, 0, 0);
        for (int c = 2; c <= 5; c++) begin
            step_in(1, 1, 2'b11, 0, 0, 0);
            if (c <= 4) chk($sformatf("b2b.stall@%0d", c), int'(mdu_if.mstall), 1);
        end
        chk("b2b.hilo_we@5", int'(mdu_if.hilo_we), 1);
        chk("b2b.stall@5", int'(mdu_if.mstall), 0);
        step_in(1, 0, 2'b00, 0, 0, 0);
        chk_all("b2b@6", 1'b1, 2'b11, 31, 1'b1, 1'b0, 1'b0);

        // Reset mid-div drops the pending op and its write.
        step_in(0, 0, 2'b00, 0, 0, 0);
        step_in(1, 1, 2'b10, 0, 0, 0);
        for (int c = 1; c <= 14; c++) step_in(1, 0, 2'b00, 0, 0, 0);
        step_in(0, 0, 2'b00, 0, 0, 0);
        chk("rst.busy@15", int'(mdu_if.mbusy), 1);
        step_in(1, 0, 2'b00, 1, 0, 0);
        chk_all("rst@16", 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 17; c < 57; c++) begin
            step_in(1, 0, 2'b00, 0, 0, 0);
            chk($sformatf("rst.no_we@%0d", c), int'(mdu_if.hilo_we), 0);
        end

        // Randomized run against the timestamp model.
        step_in(0, 0, 2'b00, 0, 0, 0);
        m_run = 1'b0; m_end = -10; m_start = -1; m_done = -1; m_mop = 2'b00; m_frz = 0;
        for (int c = 0; c < 3000; c++) begin
            bit rn, iss, mf, wp, cn, e_done, acc;
            logic [1:0] o;
            int e_cnt;
            rn  = ($urandom_range(0, 199) != 0);
            iss = ($urandom_range(0, 2) == 0);
            o   = 2'($urandom_range(0, 3));
            mf  = ($urandom_range(0, 3) == 0);
            wp  = ($urandom_range(0, 3) == 0);
            cn  = ($urandom_range(0, 63) == 0);
            step_in(rn, iss, o, mf, wp, cn);
            e_done = (c == m_done);
            e_cnt  = m_run ? (m_end - c) : m_frz;
            chk_all($sformatf("rnd@%0d", c), (c == m_start), m_mop, e_cnt, m_run, e_done,
                    (m_run && (iss || mf)) || (e_done && mf));
            if (!rn) begin
                m_run = 1'b0; m_start = -1; m_done = -1; m_mop = 2'b00; m_frz = 0;
            end else begin
                acc = iss && !wp && !cn && !m_run;
                if (m_run && cn) begin
                    m_run = 1'b0;
                    m_frz = m_end - c;
                end else if (m_run && (c == m_end)) begin
                    m_run  = 1'b0;
                    m_done = c + 1;
                    m_frz  = 0;
                end
                if (acc) begin
                    m_run   = 1'b1;
                    m_start = c + 1;
                    m_end   = c + (o[1] ? DIVC : MULC);
                    m_mop   = o;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
